capture_writer: RTL and testbench

CAPTURE_WRITER -- requirements
Module: capture_writer

---
 rtl/capture_writer.sv | 119 +++++++++++
 tb/tb_capture_writer.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/capture_writer.sv
// Ping-pong capture writer: streams ADC samples into two BRAM banks, hands each full bank to a
// reader, and drops samples (counting them) while both banks are owned by the reader.
module capture_writer #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   input  logic                  rd_done,
   input  logic                  rd_bank,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  addrSel,
   output logic                  bank_ready,
   output logic                  ready_bank,
   output logic [15:0]           overflow_cnt,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StFill, StHold} state_e;

   state_e                state;
   logic                  wr_bank;
   logic [ADDR_WIDTH-1:0] ptr;
   logic [1:0]            full;
   logic                  done_pend;
   logic                  done_bank;

   logic [1:0]            rd_clr;
   logic [1:0]            full_clr;
   logic                  other_free;
   logic                  ptr_last;

   // Reader releases are applied before ownership decisions so a same-cycle release counts.
   always_comb begin
      rd_clr     = rd_done ? (2'b01 << rd_bank) : 2'b00;
      full_clr   = full & ~rd_clr;
      other_free = ~full_clr[~wr_bank];
      ptr_last   = (ptr == {ADDR_WIDTH{1'b1}});
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= StIdle;
         wr_bank      <= 1'b0;
         ptr          <= '0;
         full         <= 2'b00;
         done_pend    <= 1'b0;
         done_bank    <= 1'b0;
         wr_en        <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         addrSel      <= 1'b0;
         bank_ready   <= 1'b0;
         ready_bank   <= 1'b0;
         overflow_cnt <= '0;
         busy         <= 1'b0;
      end else begin
         wr_en      <= 1'b0;
         full       <= full_clr;
         // Completion is announced one cycle after the final write is on the port.
         done_pend  <= 1'b0;
         bank_ready <= done_pend;
         if (done_pend) ready_bank <= done_bank;

         unique case (state)
            StIdle: begin
               if (enable) begin
                  state <= StFill;
                  busy  <= 1'b1;
                  ptr   <= '0;
               end
            end
            StFill: begin
               if (!enable) begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  ptr   <= '0;
               end else if (sample_valid) begin
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= sample_data;
                  addrSel <= wr_bank;
                  ptr     <= ptr + 1'b1;
                  if (ptr_last) begin
                     // Set wins over a same-cycle release of this bank.
                     full      <= full_clr | (2'b01 << wr_bank);
                     done_pend <= 1'b1;
                     done_bank <= wr_bank;
                     if (other_free) wr_bank <= ~wr_bank;
                     else            state   <= StHold;
                  end
               end
            end
            StHold: begin
               if (sample_valid && overflow_cnt != 16'hFFFF) overflow_cnt <= overflow_cnt + 16'd1;
               if (!enable) begin
                  state <= StIdle;
                  busy  <= 1'b0;
                  ptr   <= '0;
               end else if (other_free) begin
                  state   <= StFill;
                  wr_bank <= ~wr_bank;
                  ptr     <= '0;
               end
            end
            default: begin
               state <= StIdle;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_capture_writer.sv
// Directed bench for capture_writer with 16-entry banks.
module tb_capture_writer;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        sample_valid;
   logic [7:0]  sample_data;
   logic        rd_done;
   logic        rd_bank;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [7:0]  wr_data;
   logic        addrSel;
   logic        bank_ready;
   logic        ready_bank;
   logic [15:0] overflow_cnt;
   logic        busy;

   int passed = 0;
   int total  = 0;

   capture_writer #(
      .DATA_WIDTH (8),
      .ADDR_WIDTH (4)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_valid (sample_valid),
      .sample_data  (sample_data),
      .rd_done      (rd_done),
      .rd_bank      (rd_bank),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .addrSel      (addrSel),
      .bank_ready   (bank_ready),
      .ready_bank   (ready_bank),
      .overflow_cnt (overflow_cnt),
      .busy         (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One accepted sample: the write must appear on the port right after the accepting edge.
   task automatic send(input logic [7:0] d, input logic [3:0] a, input logic b);
      sample_valid = 1'b1;
      sample_data  = d;
      step();
      chk("wr_en", {31'd0, wr_en}, 32'd1);
      chk("wr_addr", {28'd0, wr_addr}, {28'd0, a});
      chk("wr_data", {24'd0, wr_data}, {24'd0, d});
      chk("addrSel", {31'd0, addrSel}, {31'd0, b});
   endtask

   task automatic chk_reset_outputs();
      chk("rst wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst wr_addr", {28'd0, wr_addr}, 32'd0);
      chk("rst wr_data", {24'd0, wr_data}, 32'd0);
      chk("rst addrSel", {31'd0, addrSel}, 32'd0);
      chk("rst bank_ready", {31'd0, bank_ready}, 32'd0);
      chk("rst ready_bank", {31'd0, ready_bank}, 32'd0);
      chk("rst overflow_cnt", {16'd0, overflow_cnt}, 32'd0);
      chk("rst busy", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst_n        = 1'b0;
      enable       = 1'b0;
      sample_valid = 1'b0;
      sample_data  = 8'h00;
      rd_done      = 1'b0;
      rd_bank      = 1'b0;

      // Reset values
      step();
      step();
      chk_reset_outputs();
      rst_n = 1'b1;
      step();
      chk("idle busy", {31'd0, busy}, 32'd0);

      // Continuous fill of bank 0, then first sample of bank 1
      enable = 1'b1;
      step();
      chk("fill busy", {31'd0, busy}, 32'd1);
      chk("fill no write yet", {31'd0, wr_en}, 32'd0);
      for (int i = 0; i < 16; i++) begin
         send(8'(i), 4'(i), 1'b0);
         chk("no early bank_ready", {31'd0, bank_ready}, 32'd0);
      end
      send(8'h10, 4'd0, 1'b1);
      chk("bank0 ready", {31'd0, bank_ready}, 32'd1);
      chk("bank0 ready_bank", {31'd0, ready_bank}, 32'd0);

      // Fill rest of bank 1 with bank 0 unreleased -> HOLD, drop 16 samples
      for (int i = 1; i < 16; i++) send(8'(8'h10 + i), 4'(i), 1'b1);
      for (int i = 0; i < 16; i++) begin
         step();
         chk("hold wr_en", {31'd0, wr_en}, 32'd0);
         if (i == 0) begin
            chk("bank1 ready", {31'd0, bank_ready}, 32'd1);
            chk("bank1 ready_bank", {31'd0, ready_bank}, 32'd1);
         end
      end
      sample_valid = 1'b0;
      chk("overflow 16", {16'd0, overflow_cnt}, 32'd16);
      chk("hold busy", {31'd0, busy}, 32'd1);
      chk("hold addrSel held", {31'd0, addrSel}, 32'd1);

      // Release bank 0 while in HOLD
      rd_done = 1'b1;
      rd_bank = 1'b0;
      step();
      rd_done = 1'b0;
      send(8'hA0, 4'd0, 1'b0);
      chk("overflow unchanged", {16'd0, overflow_cnt}, 32'd16);

      // Bank 0 completes in the same cycle bank 1 is released -> no HOLD
      for (int i = 1; i < 15; i++) send(8'(8'hA0 + i), 4'(i), 1'b0);
      rd_done = 1'b1;
      rd_bank = 1'b1;
      send(8'hAF, 4'd15, 1'b0);
      rd_done = 1'b0;
      send(8'hB0, 4'd0, 1'b1);
      chk("simul overflow", {16'd0, overflow_cnt}, 32'd16);

      // Abort after 5 more samples, then re-enable in the same bank
      for (int i = 1; i <= 5; i++) send(8'(8'hB0 + i), 4'(i), 1'b1);
      enable = 1'b0;
      step();
      chk("abort wr_en", {31'd0, wr_en}, 32'd0);
      chk("abort busy", {31'd0, busy}, 32'd0);
      chk("abort addrSel held", {31'd0, addrSel}, 32'd1);
      sample_valid = 1'b0;
      enable       = 1'b1;
      step();
      chk("reenable busy", {31'd0, busy}, 32'd1);
      send(8'hC0, 4'd0, 1'b1);

      // Bank 0 still owned by reader: filling bank 1 enters HOLD, then reset mid-HOLD
      for (int i = 1; i < 16; i++) send(8'(8'hC0 + i), 4'(i), 1'b1);
      sample_valid = 1'b0;
      step();
      chk("pre-reset ready", {31'd0, bank_ready}, 32'd1);
      chk("pre-reset ready_bank", {31'd0, ready_bank}, 32'd1);
      step();
      chk("pre-reset busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_outputs();
      step();
      rst_n = 1'b1;
      step();
      chk("post-reset busy", {31'd0, busy}, 32'd1);
      for (int i = 0; i < 16; i++) send(8'(8'hD0 + i), 4'(i), 1'b0);
      // Bank 1 must be free after reset, so capture moves straight on
      send(8'hE0, 4'd0, 1'b1);
      chk("post-reset ready_bank", {31'd0, ready_bank}, 32'd0);
      chk("post-reset bank_ready", {31'd0, bank_ready}, 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
